// File: rtl/sram_burst_ctrl_pkg.sv
// Shared types and defaults for the SRAM burst controller slice.
package sram_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
    } rsp_t;

endpackage

// File: rtl/sram_burst_ctrl_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; head entry is presented
// combinationally and stays put until popped.
module sram_rsp_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst command front end for an 8-bit single-port SRAM: expands bursts into
// registered single-beat accesses and returns read data through a credited FIFO.
module sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              sram_en,
    output logic              sram_wr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wr_data,
    input  logic [DATA_W-1:0] sram_rd_data
);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [7:0]        len;
    logic [7:0]        cnt;
    logic              sram_last;
    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_last;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_out;
    logic              has_credit;
    logic              rd_issue;
    logic              wr_fire;
    logic              rsp_push;
    logic              rsp_pop;

    assign cmd_ready   = (state == IDLE);
    assign wdata_ready = (state == WR_BURST);
    assign wr_fire     = wdata_ready && wdata_valid;
    // Every read in flight already owns a FIFO slot, so its push can never overflow.
    assign has_credit  = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(RSP_DEPTH);
    assign rd_issue    = (state == RD_BURST) && has_credit;
    assign rsp_push    = pipe_valid[RD_LAT-1];
    assign rsp_valid   = !fifo_empty;
    assign rsp_pop     = rsp_valid && rsp_ready;
    assign rsp_data    = fifo_out[DATA_W-1:0];
    assign rsp_last    = fifo_out[DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            base         <= '0;
            len          <= '0;
            cnt          <= '0;
            sram_en      <= 1'b0;
            sram_wr      <= 1'b0;
            sram_addr    <= '0;
            sram_wr_data <= '0;
            sram_last    <= 1'b0;
        end else begin
            sram_en   <= 1'b0;
            sram_wr   <= 1'b0;
            sram_last <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        base  <= cmd_addr;
                        len   <= cmd_len;
                        cnt   <= '0;
                        state <= cmd_wr ? WR_BURST : RD_BURST;
                    end
                end
                WR_BURST: begin
                    if (wr_fire) begin
                        sram_en      <= 1'b1;
                        sram_wr      <= 1'b1;
                        sram_addr    <= base + ADDR_W'(cnt);
                        sram_wr_data <= wdata;
                        cnt          <= cnt + 8'd1;
                        if (cnt == len) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    if (rd_issue) begin
                        sram_en   <= 1'b1;
                        sram_addr <= base + ADDR_W'(cnt);
                        sram_last <= (cnt == len);
                        cnt       <= cnt + 8'd1;
                        if (cnt == len) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            inflight   <= '0;
        end else begin
            pipe_valid[0] <= sram_en && !sram_wr;
            pipe_last[0]  <= sram_last;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
            end
            case ({rd_issue, rsp_push})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    sram_rsp_fifo #(
        .WIDTH(DATA_W + 1),
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rsp_push),
        .push_data({pipe_last[RD_LAT-1], sram_rd_data}),
        .pop      (rsp_pop),
        .pop_data (fifo_out),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
- Request-side driver for the 8-bit SRAM port (en/wr/addr/wr_data/rd_data); sits directly upstream of the SRAM and drives its inputs.
- Accepts burst commands over valid/ready and expands each into single-beat SRAM accesses with incrementing addresses.
- Captures rd_data after a fixed read latency and returns it through a credit-protected response FIFO.

Parameters:
- ADDR_W, 32, SRAM address width.
- DATA_W, 8, SRAM data width.
- RD_LAT, 1, cycles from the edge where sram_en=1 && !sram_wr is presented to the edge where sram_rd_data is valid; legal range 1..4.
- RSP_DEPTH, 4, response FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  8  beats minus 1 (0 means 1 beat, 255 means 256 beats).
- wdata_valid  in  1  write beat available.
- wdata_ready  out  1  high in WR_BURST; a beat transfers when valid && ready.
- wdata  in  DATA_W  write beat data.
- rsp_valid  out  1  read response available (FIFO not empty).
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  read data.
- rsp_last  out  1  marks the final beat of a read burst.
- sram_en  out  1  SRAM access strobe.
- sram_wr  out  1  SRAM write select.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wr_data  out  DATA_W  SRAM write data.
- sram_rd_data  in  DATA_W  SRAM read data.

Behaviour:
- Reset values: sram_en, sram_wr, sram_addr, sram_wr_data = 0; rsp_valid = 0; FSM in IDLE; FIFO empty; pipeline empty; cmd_ready = 1.
- Reset is asynchronous and may occur mid-burst; any partial burst, in-flight reads and buffered responses are discarded.
- All sram_* outputs are registered. A beat issued at edge T drives the SRAM from T+1 for exactly one cycle; sram_en is never high for two cycles from a single beat.
- FSM state IDLE: on cmd_valid, latch addr, len and wr; set beat counter = 0. Next state is WR_BURST if cmd_wr=1, otherwise RD_BURST. There are no SRAM accesses in the acceptance cycle.
- FSM state WR_BURST:
  - wdata_ready = 1.
  - Each fire issues en=1, wr=1, addr = base + cnt, wr_data = wdata.
  - Cycles with no fire issue en=0.
  - After the beat where cnt == len, return to IDLE.
- FSM state RD_BURST:
  - Issue en=1, wr=0 when credit > 0.
  - credit = RSP_DEPTH − fifo_count − inflight_reads.
  - No credit means stall with en=0.
  - After the beat where cnt == len, return to IDLE.
- Read capture:
  - A shift register of depth RD_LAT carries {valid, last} alongside each read.
  - sram_rd_data is pushed to the FIFO RD_LAT cycles after sram_en was sampled high.
  - The push is guaranteed by the credit check; overflow is impossible, and an assertion flags it.
- Reads still in flight or buffered do not block a new command: IDLE may accept the next command while the FIFO drains. Response order equals issue order.
- Address arithmetic: ADDR_W-bit modulo, so 0xFFFF_FFFF + 1 wraps to 0x0000_0000. cnt is 8 bits; cnt == len ends the burst.
- FIFO:
  - Simultaneous push and pop when full or empty is handled; count stays consistent.
  - Pop occurs when rsp_valid && rsp_ready.
  - rsp_data, rsp_last and rsp_valid come from FIFO head and are stable while rsp_valid && !rsp_ready.
- A cmd_valid drop in IDLE is legal. wdata_valid outside WR_BURST is ignored.

Decomposition:
- Package sram_pkg holds ADDR_W/DATA_W defaults, the state enum typedef (IDLE, WR_BURST, RD_BURST) and the response struct typedef {data, last}.
- One sub-module, sram_rsp_fifo: a parameterised synchronous FIFO (width DATA_W+1, depth RSP_DEPTH) with count output.

Test Plan:
- Single write then single read:
  - Stimulus: write addr 0x10 len 0 data 0xA5, then read addr 0x10 len 0, with rsp_ready=1 and a model SRAM of RD_LAT=1.
  - Required: sram_en high for exactly 1 cycle with wr=1, addr=0x10, data=0xA5; then rsp_data=0xA5, rsp_last=1, 3 cycles after read cmd acceptance.
- Write burst addr 0x20 len 3, data 0x01..0x04 with a wdata_valid gap after beat 2:
  - Required: sram writes to 0x20..0x23 in order, en=0 during the gap, then return to IDLE.
- Address wrap: read burst at addr 0xFFFF_FFFE len 3 -> sram_addr sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- Backpressure: rsp_ready=0 during a read burst of len 7 with RSP_DEPTH=4:
  - Required: exactly 4 reads issued, then en stays low; no FIFO overflow.
  - After rsp_ready=1, all 8 responses arrive in order and rsp_last is set on the 8th only.
- Reset mid-burst: assert rst_n=0 during beat 2 of a read burst of len 5:
  - Required: all sram_* outputs go to 0 immediately (async) and rsp_valid=0.
  - After release: cmd_ready=1 and no stale responses appear.
- RD_LAT=3 back-to-back: read len 1 accepted, next read cmd accepted before data returns -> 4 responses in order, last flags on beats 2 and 4.
